eq_band_sched: RTL and testbench



---
 rtl/eq_band_sched.sv | 140 ++++++++++++++
 tb/tb_eq_band_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/eq_band_sched.sv
// Equalizer band scheduler: one shared square/multiply/saturate pipeline walks all
// bands of a snapshotted sample and accumulates a saturated equalized output.
module eq_band_sched #(
    parameter int NUM_BANDS = 5,
    parameter int ACC_W     = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    smpl_vld,
    input  logic [16*NUM_BANDS-1:0] aud_bus,
    input  logic [12*NUM_BANDS-1:0] pot_bus,
    input  logic                    clr_ovr,
    output logic [15:0]             eq_out,
    output logic                    eq_vld,
    output logic                    busy,
    output logic                    overrun
);
    localparam int IW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int CW = (IW < 2) ? 2 : IW;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic signed [ACC_W-1:0] OUT_MAX = 32767;
    localparam logic signed [ACC_W-1:0] OUT_MIN = -32768;

    logic [1:0]                  state;
    logic [CW-1:0]               cnt;
    logic [IW-1:0]               idx;
    logic [NUM_BANDS-1:0][15:0]  aud_r;
    logic [NUM_BANDS-1:0][11:0]  pot_r;
    logic [23:0]                 sq;
    logic signed [15:0]          aud1;
    logic signed [28:0]          prod;
    logic [1:0]                  vld_pipe;
    logic signed [ACC_W-1:0]     acc;

    logic                        accept, drop;
    logic signed [12:0]          scale;
    logic signed [28:0]          scale_x, aud_x;
    logic signed [15:0]          band_res;
    logic signed [ACC_W-1:0]     band_ext;
    logic [15:0]                 acc_clip;

    assign idx     = cnt[IW-1:0];
    assign busy    = (state == ISSUE) || (state == DRAIN);
    assign accept  = smpl_vld && ((state == IDLE) || (state == DONE));
    assign drop    = smpl_vld && busy;

    assign scale   = {1'b0, sq[23:12]};
    assign scale_x = scale;
    assign aud_x   = aud1;

    // prod[28:25] not all equal means the band value does not fit in 16 bits after >>10
    always_comb begin
        band_res = prod[25:10];
        if (prod[28:25] != {4{prod[28]}})
            band_res = prod[28] ? 16'sh8000 : 16'sh7FFF;
    end
    assign band_ext = band_res;

    always_comb begin
        acc_clip = acc[15:0];
        if (acc > OUT_MAX)      acc_clip = 16'h7FFF;
        else if (acc < OUT_MIN) acc_clip = 16'h8000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            aud_r    <= '0;
            pot_r    <= '0;
            sq       <= '0;
            aud1     <= '0;
            prod     <= '0;
            vld_pipe <= '0;
            acc      <= '0;
            eq_out   <= '0;
            eq_vld   <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            eq_vld <= 1'b0;

            if (drop)         overrun <= 1'b1;
            else if (clr_ovr) overrun <= 1'b0;

            vld_pipe[0] <= (state == ISSUE);
            vld_pipe[1] <= vld_pipe[0];
            if (state == ISSUE) begin
                sq   <= 24'(pot_r[idx]) * 24'(pot_r[idx]);
                aud1 <= aud_r[idx];
            end
            if (vld_pipe[0])
                prod <= scale_x * aud_x;

            // The pipeline is empty whenever a sample is accepted, so clearing is safe
            if (accept)           acc <= '0;
            else if (vld_pipe[1]) acc <= acc + band_ext;

            if (accept) begin
                aud_r <= aud_bus;
                pot_r <= pot_bus;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ISSUE;
                        cnt   <= '0;
                    end
                end
                ISSUE: begin
                    if (cnt == CW'(NUM_BANDS - 1)) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == CW'(2)) begin
                        state  <= DONE;
                        cnt    <= '0;
                        eq_out <= acc_clip;
                        eq_vld <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= accept ? ISSUE : IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_eq_band_sched.sv
// Bench for eq_band_sched: directed scenarios plus random samples, each result
// compared against an arithmetic model of the band gain and saturation rules.
module tb_eq_band_sched;
    localparam int NB = 5;
    localparam int LAT = NB + 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               smpl_vld;
    logic [16*NB-1:0]   aud_bus;
    logic [12*NB-1:0]   pot_bus;
    logic               clr_ovr;
    logic [15:0]        eq_out;
    logic               eq_vld;
    logic               busy;
    logic               overrun;

    int n_asrt = 0;
    int n_fail = 0;
    int m_aud[NB];
    int m_pot[NB];

    eq_band_sched #(.NUM_BANDS(NB), .ACC_W(20)) dut (
        .clk(clk), .rst(rst), .smpl_vld(smpl_vld), .aud_bus(aud_bus),
        .pot_bus(pot_bus), .clr_ovr(clr_ovr), .eq_out(eq_out),
        .eq_vld(eq_vld), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Gain is floor(pot^2 / 4096) / 1024; each band clips to int16, then the sum clips.
    function automatic logic [15:0] model();
        longint s = 0;
        for (int b = 0; b < NB; b++) begin
            longint g = (longint'(m_pot[b]) * m_pot[b]) / 4096;
            longint p = g * m_aud[b];
            longint r = p >>> 10;
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
            s += r;
        end
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic set_all(input int a, input int p);
        for (int b = 0; b < NB; b++) begin
            m_aud[b] = a;
            m_pot[b] = p;
        end
    endtask

    task automatic randomize_model();
        for (int b = 0; b < NB; b++) begin
            m_pot[b] = int'($urandom_range(0, 4095));
            m_aud[b] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    // Drive the sample for one cycle; scramble the buses afterwards to prove the snapshot.
    task automatic send();
        for (int b = 0; b < NB; b++) begin
            aud_bus[16*b +: 16] = 16'(m_aud[b]);
            pot_bus[12*b +: 12] = 12'(m_pot[b]);
        end
        smpl_vld = 1'b1;
        @(negedge clk);
        smpl_vld = 1'b0;
        aud_bus = {$urandom, $urandom, $urandom};
        pot_bus = {$urandom, $urandom};
    endtask

    // Called at the negedge of cycle T+1; returns at the negedge of cycle T+LAT.
    task automatic watch(input string tag, input logic [15:0] exp, input int drop_k);
        for (int k = 1; k <= LAT; k++) begin
            chk({tag, "_busy"}, 32'(busy), 32'(k <= LAT - 1));
            chk({tag, "_vld"}, 32'(eq_vld), 32'(k == LAT));
            if (k == LAT) chk({tag, "_out"}, 32'(eq_out), 32'(exp));
            if (k == drop_k) begin
                aud_bus = {$urandom, $urandom, $urandom};
                pot_bus = {$urandom, $urandom};
                smpl_vld = 1'b1;
            end
            if (k < LAT) begin
                @(negedge clk);
                smpl_vld = 1'b0;
            end
        end
    endtask

    initial begin
        logic [15:0] exp_a;
        rst = 1'b1; smpl_vld = 1'b0; clr_ovr = 1'b0; aud_bus = '0; pot_bus = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out", 32'(eq_out), 32'h0);
        chk("rst_vld", 32'(eq_vld), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);

        // Unity gain, single band
        set_all(0, 12'h800); m_aud[0] = 1000;
        send(); watch("unity", 16'd1000, 0);
        chk("unity_model", 32'(model()), 32'd1000);
        @(negedge clk); chk("unity_vld_once", 32'(eq_vld), 32'h0);

        // Sum overflow both directions
        set_all(32767, 12'h800);
        send(); watch("sum_pos", 16'h7FFF, 0); @(negedge clk);
        set_all(-32768, 12'h800);
        send(); watch("sum_neg", 16'h8000, 0); @(negedge clk);

        // Per-band saturation on band 2
        set_all(0, 0); m_pot[2] = 12'hFFF; m_aud[2] = 16000;
        send(); watch("band_pos", 16'h7FFF, 0); @(negedge clk);
        m_aud[2] = -20000;
        send(); watch("band_neg", 16'h8000, 0); @(negedge clk);
        m_aud[2] = 4000;
        send(); watch("band_gain", 16'd15992, 0); @(negedge clk);

        // Overrun: drop at T+3, no second result
        randomize_model(); exp_a = model();
        send(); watch("ovr", exp_a, 3);
        chk("ovr_set", 32'(overrun), 32'h1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("ovr_no_vld", 32'(eq_vld), 32'h0);
        end
        chk("ovr_hold", 32'(eq_out), 32'(exp_a));
        clr_ovr = 1'b1; @(negedge clk); clr_ovr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'h0);

        // Back-to-back: second sample issued in the DONE cycle
        randomize_model(); exp_a = model();
        send(); watch("b2b_a", exp_a, 0);
        randomize_model(); exp_a = model();
        send(); watch("b2b_b", exp_a, 0);
        chk("b2b_ovr", 32'(overrun), 32'h0);
        @(negedge clk);

        // Reset mid-run at T+4
        randomize_model();
        send();
        for (int k = 1; k < 4; k++) begin
            chk("mid_busy", 32'(busy), 32'h1);
            @(negedge clk);
        end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("mid_busy0", 32'(busy), 32'h0);
        chk("mid_out0", 32'(eq_out), 32'h0);
        for (int i = 0; i < 10; i++) begin
            chk("mid_no_vld", 32'(eq_vld), 32'h0);
            @(negedge clk);
        end
        randomize_model(); exp_a = model();
        send(); watch("after_rst", exp_a, 0); @(negedge clk);

        // Random samples
        for (int n = 0; n < 20; n++) begin
            randomize_model(); exp_a = model();
            send(); watch("rand", exp_a, 0);
            if (n[0]) @(negedge clk);
        end
        @(negedge clk);
        chk("final_ovr", 32'(overrun), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
